noc_inject_arbiter: RTL and testbench
=====================================

# noc_inject_arbiter

Packet-granular injection arbiter for one NoC endpoint port of the ring. It shares a single router local input (port 0) among `NUM_REQ` local requesters using round-robin arbitration. Once a packet is granted, it stays locked to that requester until the tail flit is sent. The block tracks the router's input-buffer credits and issues flits only when a credit is available. It sits between the endpoint's traffic sources and the `data_in/dest_in/is_tail_in/send_in/credit_out` slice of the ring for that endpoint.

## Interface
Parameters:
- `NUM_REQ`, 4, number of local requesters (≥2)
- `DEST_WIDTH`, 4, destination field width (matches ring)
- `FLIT_WIDTH`, 256, flit payload width (matches ring)
- `FLIT_BUFFER_DEPTH`, 2, router input buffer depth; initial and maximum credit count

Ports:
- `clk`  in  1  single clock, all logic rising-edge
- `rst`  in  1  reset; synchronous, active-high
- `req_valid`  in  [NUM_REQ]  requester i presents a flit
- `req_data`  in  [NUM_REQ][FLIT_WIDTH]  flit payload per requester
- `req_dest`  in  [NUM_REQ][DEST_WIDTH]  destination per requester; sampled per flit
- `req_is_tail`  in  [NUM_REQ]  flit is the last of its packet
- `req_ready`  out  [NUM_REQ]  flit i accepted this cycle when `req_valid[i] & req_ready[i]`
- `data_out`  out  FLIT_WIDTH  to router `data_in`
- `dest_out`  out  DEST_WIDTH  to router `dest_in`
- `is_tail_out`  out  1  to router `is_tail_in`
- `send_out`  out  1  one-cycle pulse per flit, to router `send_in`
- `credit_in`  in  1  from router `credit_out`; one pulse = one buffer slot freed
- `grant_id`  out  $clog2(NUM_REQ)  requester index of the flit currently on `send_out`
- `credit_err`  out  1  sticky; set when a credit is returned while the counter is at `FLIT_BUFFER_DEPTH`

## Operation
- **Credit counter `cnt`:**
  - Width `$clog2(FLIT_BUFFER_DEPTH+1)`.
  - Next value = `cnt - accept + credit_in`. Accept and credit in the same cycle leave it unchanged.
  - `credit_in` at `cnt==FLIT_BUFFER_DEPTH` with no accept: `cnt` saturates and `credit_err` is set (cleared only by `rst`).
  - Accept is never possible at `cnt==0`, so there is no underflow.
- **FSM `IDLE` / `LOCKED`; owner register `own`; round-robin pointer `ptr`:**
  - **IDLE:**
    - If `cnt>0` and any `req_valid`, the winner is the first valid index searching from `ptr` upward with wrap-around.
    - `req_ready[winner]=1`; all other `req_ready` bits are 0. The flit is accepted.
    - Accepted flit not tail → go to `LOCKED` with `own=winner`.
    - Accepted flit is tail → stay in `IDLE`, `ptr=(winner+1) mod NUM_REQ`.
  - **LOCKED:**
    - `req_ready[own] = (cnt>0)`; all other `req_ready` bits are 0.
    - Accepting a tail flit from `own` → go to `IDLE`, `ptr=(own+1) mod NUM_REQ`.
    - If `own` deasserts `req_valid` mid-packet, the lock holds. Idle cycles are inserted and no other requester is served; interleaving packets is forbidden.
- `req_ready` is combinational from state, `ptr`, `cnt` and `req_valid`. `req_ready[i]` is never 1 when `cnt==0`.
- **Output register:**
  - Loaded on accept with `req_data`, `req_dest`, `req_is_tail` and the granted index.
  - `send_out=1` in the following cycle only. Data and dest hold their last value when `send_out=0`.
- **Reset values:**
  - Outputs: `send_out=0`, `data_out=0`, `dest_out=0`, `is_tail_out=0`, `grant_id=0`, `credit_err=0`.
  - Internal state: `cnt=FLIT_BUFFER_DEPTH`, `ptr=0`, `own=0`, FSM `IDLE`.
- **Reset mid-packet:** the partial packet is abandoned and all state returns to reset values. Recovering router-side state is the system's responsibility.

## Timing
- Accept in cycle t → `send_out` in cycle t+1. Fixed latency of 1; throughput 1 flit/cycle while `cnt>0`.
- `credit_in` in cycle t updates `cnt` at t+1. The earliest accept it enables is t+1, with `send_out` at t+2. There is no same-cycle credit bypass.
- `cnt` decrements at the accept edge, not at `send_out`.
- Tail accepted in cycle t → a new arbitration (possibly a different requester) may accept in cycle t+1. There is no dead cycle between packets.

## Test plan
- **Round-robin, single-flit packets:** `FLIT_BUFFER_DEPTH=2`, `credit_in` tied to the previous cycle's `send_out`; all 4 requesters hold valid single-flit packets from cycle 0.
  - Required: `grant_id` sequence on `send_out` is 0,1,2,3,0,…
  - Required: `cnt` never exceeds 2 and `credit_err` stays 0.
- **Packet lock:** req0 sends a 3-flit packet (tail on flit 3) while req1 is valid throughout.
  - Required: `grant_id` = 0,0,0,1 on consecutive `send_out` pulses, and `req_ready[1]=0` until req0's tail is accepted.
- **Credit stall:** `credit_in=0`, req2 sends a 4-flit packet.
  - Required: two flits issue, then `req_ready[2]=0`.
  - A `credit_in` pulse at cycle 10 → accept at cycle 11, `send_out` at cycle 12.
- **Simultaneous accept and credit:** `cnt=1`, accept and `credit_in` in the same cycle.
  - Required: `cnt` remains 1 and the next accept occurs on the following cycle.
- **Credit overflow:** `cnt=2`, idle requesters, one `credit_in` pulse.
  - Required: `cnt` stays 2 and `credit_err` goes to 1 and stays high until `rst`.
- **Reset mid-packet:** assert `rst` while `LOCKED` with `own=3` after a 2-of-4 flit packet.
  - Required next cycle: `send_out=0`, all `req_ready` computed from `ptr=0`, `cnt=2`, `credit_err=0`.

Source files
------------

// File: rtl/noc_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : noc_inject_arbiter
// Brief    : Packet-granular round-robin injection arbiter with credit-based
//            flow control into router local input port 0.
// Revision : 1.0
// ============================================================================
module noc_inject_arbiter #(
    parameter int NUM_REQ           = 4,
    parameter int DEST_WIDTH        = 4,
    parameter int FLIT_WIDTH        = 256,
    parameter int FLIT_BUFFER_DEPTH = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [NUM_REQ-1:0]                   req_valid,
    input  logic [NUM_REQ-1:0][FLIT_WIDTH-1:0]   req_data,
    input  logic [NUM_REQ-1:0][DEST_WIDTH-1:0]   req_dest,
    input  logic [NUM_REQ-1:0]                   req_is_tail,
    output logic [NUM_REQ-1:0]                   req_ready,
    output logic [FLIT_WIDTH-1:0]                data_out,
    output logic [DEST_WIDTH-1:0]                dest_out,
    output logic                                 is_tail_out,
    output logic                                 send_out,
    input  logic                                 credit_in,
    output logic [$clog2(NUM_REQ)-1:0]           grant_id,
    output logic                                 credit_err
);

    localparam int c_id_w  = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(FLIT_BUFFER_DEPTH + 1);

    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(FLIT_BUFFER_DEPTH);
    localparam logic [c_id_w-1:0]  c_last_id = c_id_w'(NUM_REQ - 1);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_locked = 1'b1;

    logic [0:0]            r_state;
    logic [c_id_w-1:0]     r_own;
    logic [c_id_w-1:0]     r_ptr;
    logic [c_cnt_w-1:0]    r_cnt;
    logic                  r_credit_err;
    logic                  r_send;
    logic [FLIT_WIDTH-1:0] r_data;
    logic [DEST_WIDTH-1:0] r_dest;
    logic                  r_tail;
    logic [c_id_w-1:0]     r_gid;

    logic                  w_found;
    logic [c_id_w-1:0]     w_winner;
    logic [c_id_w-1:0]     w_cand;
    logic                  w_cnt_nz;
    logic [NUM_REQ-1:0]    w_ready;
    logic [c_id_w-1:0]     w_sel;
    logic                  w_accept;
    logic                  w_sel_tail;
    logic [c_id_w-1:0]     w_ptr_inc;
    logic [0:0]            w_state_nxt;
    logic [c_id_w-1:0]     w_own_nxt;
    logic [c_id_w-1:0]     w_ptr_nxt;
    logic [c_cnt_w-1:0]    w_cnt_nxt;
    logic                  w_err_set;

    assign w_cnt_nz = (r_cnt != '0);

    // First valid requester at or above r_ptr, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = c_id_w'((int'(r_ptr) + k) % NUM_REQ);
            if (!w_found && req_valid[w_cand]) begin
                w_found  = 1'b1;
                w_winner = w_cand;
            end
        end
    end

    always_comb begin
        w_ready = '0;
        w_sel   = w_winner;
        case (r_state)
            c_st_idle: begin
                if (w_cnt_nz && w_found) begin
                    w_ready[w_winner] = 1'b1;
                end
            end
            default: begin
                // Lock holds even if the owner drops valid mid-packet.
                w_sel          = r_own;
                w_ready[r_own] = w_cnt_nz;
            end
        endcase
    end

    assign w_accept   = |(req_valid & w_ready);
    assign w_sel_tail = req_is_tail[w_sel];
    assign w_ptr_inc  = (w_sel == c_last_id) ? '0 : w_sel + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_own_nxt   = r_own;
        w_ptr_nxt   = r_ptr;
        if (w_accept) begin
            if (w_sel_tail) begin
                w_state_nxt = c_st_idle;
                w_ptr_nxt   = w_ptr_inc;
            end else begin
                w_state_nxt = c_st_locked;
                w_own_nxt   = w_sel;
            end
        end
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        w_err_set = 1'b0;
        case ({w_accept, credit_in})
            2'b10: w_cnt_nxt = r_cnt - 1'b1;
            2'b01: begin
                if (r_cnt == c_cnt_max) begin
                    w_err_set = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_own        <= '0;
            r_ptr        <= '0;
            r_cnt        <= c_cnt_max;
            r_credit_err <= 1'b0;
            r_send       <= 1'b0;
            r_data       <= '0;
            r_dest       <= '0;
            r_tail       <= 1'b0;
            r_gid        <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_own        <= w_own_nxt;
            r_ptr        <= w_ptr_nxt;
            r_cnt        <= w_cnt_nxt;
            r_credit_err <= r_credit_err | w_err_set;
            r_send       <= w_accept;
            if (w_accept) begin
                r_data <= req_data[w_sel];
                r_dest <= req_dest[w_sel];
                r_tail <= w_sel_tail;
                r_gid  <= w_sel;
            end
        end
    end

    assign req_ready   = w_ready;
    assign data_out    = r_data;
    assign dest_out    = r_dest;
    assign is_tail_out = r_tail;
    assign send_out    = r_send;
    assign grant_id    = r_gid;
    assign credit_err  = r_credit_err;

endmodule
`default_nettype wire

// File: tb/tb_noc_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_noc_inject_arbiter
// Brief    : Directed self-checking bench for noc_inject_arbiter.
// Revision : 1.0
// ============================================================================
module tb_noc_inject_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DEST_WIDTH = 4;
    localparam int FLIT_WIDTH = 256;
    localparam int DEPTH      = 2;

    logic                                 clk = 1'b0;
    logic                                 rst;
    logic [NUM_REQ-1:0]                   req_valid;
    logic [NUM_REQ-1:0][FLIT_WIDTH-1:0]   req_data;
    logic [NUM_REQ-1:0][DEST_WIDTH-1:0]   req_dest;
    logic [NUM_REQ-1:0]                   req_is_tail;
    logic [NUM_REQ-1:0]                   req_ready;
    logic [FLIT_WIDTH-1:0]                data_out;
    logic [DEST_WIDTH-1:0]                dest_out;
    logic                                 is_tail_out;
    logic                                 send_out;
    logic                                 credit_in;
    logic [1:0]                           grant_id;
    logic                                 credit_err;

    int n_chk = 0;
    int n_err = 0;

    noc_inject_arbiter #(
        .NUM_REQ           (NUM_REQ),
        .DEST_WIDTH        (DEST_WIDTH),
        .FLIT_WIDTH        (FLIT_WIDTH),
        .FLIT_BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_dest    (req_dest),
        .req_is_tail (req_is_tail),
        .req_ready   (req_ready),
        .data_out    (data_out),
        .dest_out    (dest_out),
        .is_tail_out (is_tail_out),
        .send_out    (send_out),
        .credit_in   (credit_in),
        .grant_id    (grant_id),
        .credit_err  (credit_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_dest    = '0;
        req_is_tail = '0;
        credit_in   = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Packet-lock scenario: per-cycle inputs and expected outputs.
    logic [3:0] t2_valid [6] = '{4'b0011, 4'b0010, 4'b0011, 4'b0011, 4'b0010, 4'b0000};
    logic [3:0] t2_tail  [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0011, 4'b0010, 4'b0000};
    logic [3:0] t2_ready [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0000};
    logic       t2_send  [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [1:0] t2_gid   [6] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1};
    logic       t2_tailo [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    initial begin
        int f;
        logic exp_acc;

        // Reset state
        do_reset();
        #3;
        check_eq("rst_send", send_out, 0);
        check_eq("rst_data", data_out, 0);
        check_eq("rst_dest", dest_out, 0);
        check_eq("rst_tail", is_tail_out, 0);
        check_eq("rst_gid", grant_id, 0);
        check_eq("rst_err", credit_err, 0);
        check_eq("rst_cnt", dut.r_cnt, DEPTH);
        check_eq("rst_ready", req_ready, 0);

        // Round-robin of single-flit packets, credit returned one cycle after send
        do_reset();
        req_valid   = 4'hf;
        req_is_tail = 4'hf;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_data[i] = 256'(32'hA0 + i);
            req_dest[i] = 4'(i + 5);
        end
        for (int k = 0; k < 8; k++) begin
            credit_in = send_out;
            #3;
            check_eq("rr_ready", req_ready, 4'b0001 << (k % 4));
            check_eq("rr_send", send_out, k > 0);
            if (k > 0) begin
                check_eq("rr_gid", grant_id, (k - 1) % 4);
                check_eq("rr_data", data_out, 32'hA0 + (k - 1) % 4);
                check_eq("rr_dest", dest_out, (k - 1) % 4 + 5);
            end
            check_eq("rr_cnt", dut.r_cnt, (k == 0) ? 2 : 1);
            check_eq("rr_err", credit_err, 0);
            cyc();
        end

        // Packet lock: req0 3-flit packet with a gap, req1 waiting
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req_valid   = t2_valid[k];
            req_is_tail = t2_tail[k];
            credit_in   = send_out;
            #3;
            check_eq("lock_ready", req_ready, t2_ready[k]);
            check_eq("lock_send", send_out, t2_send[k]);
            if (t2_send[k]) begin
                check_eq("lock_gid", grant_id, t2_gid[k]);
                check_eq("lock_tail", is_tail_out, t2_tailo[k]);
            end
            cyc();
        end

        // Credit stall on req2 4-flit packet, then simultaneous accept and credit
        do_reset();
        req_valid = 4'b0100;
        f = 0;
        for (int c = 0; c < 14; c++) begin
            req_dest[2]    = 4'(f);
            req_data[2]    = 256'(8'h30 + f);
            req_is_tail    = (f == 3) ? 4'b0100 : 4'b0000;
            credit_in      = (c == 10) || (c == 12) || (c == 13);
            exp_acc        = (c <= 1) || (c == 11) || (c == 13);
            #3;
            check_eq("stall_ready", req_ready, exp_acc ? 4'b0100 : 4'b0000);
            check_eq("stall_send", send_out, (c == 1) || (c == 2) || (c == 12));
            if (c == 12) begin
                check_eq("stall_gid", grant_id, 2);
                check_eq("stall_dest", dest_out, 2);
                check_eq("stall_data", data_out, 8'h32);
                check_eq("stall_cnt", dut.r_cnt, 0);
            end
            if (c == 13) check_eq("stall_cnt1", dut.r_cnt, 1);
            cyc();
            if (exp_acc) f++;
        end
        req_valid   = 4'b1000;
        req_is_tail = 4'b1000;
        credit_in   = 1'b0;
        #3;
        check_eq("simul_cnt", dut.r_cnt, 1);
        check_eq("simul_ready", req_ready, 4'b1000);
        check_eq("simul_send", send_out, 1);
        check_eq("simul_gid", grant_id, 2);
        check_eq("simul_tail", is_tail_out, 1);
        cyc();
        req_valid = '0;
        #3;
        check_eq("simul_send2", send_out, 1);
        check_eq("simul_gid2", grant_id, 3);
        check_eq("simul_cnt2", dut.r_cnt, 0);
        cyc();

        // Credit overflow at full count
        do_reset();
        #3;
        check_eq("ovf_cnt0", dut.r_cnt, 2);
        cyc();
        credit_in = 1'b1;
        #3;
        check_eq("ovf_err0", credit_err, 0);
        cyc();
        credit_in = 1'b0;
        #3;
        check_eq("ovf_cnt", dut.r_cnt, 2);
        check_eq("ovf_err", credit_err, 1);
        cyc();
        cyc();
        cyc();
        check_eq("ovf_sticky", credit_err, 1);

        // Reset mid-packet while locked to req3
        req_valid   = 4'b1000;
        req_is_tail = 4'b0000;
        for (int k = 0; k < 2; k++) begin
            credit_in = send_out;
            #3;
            check_eq("mid_ready", req_ready, 4'b1000);
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst       = 1'b0;
        req_valid = 4'b1010;
        credit_in = 1'b0;
        #3;
        check_eq("mid_send", send_out, 0);
        check_eq("mid_ready_ptr0", req_ready, 4'b0010);
        check_eq("mid_cnt", dut.r_cnt, 2);
        check_eq("mid_err", credit_err, 0);
        check_eq("mid_gid", grant_id, 0);
        check_eq("mid_data", data_out, 0);
        cyc();
        req_valid = '0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
